// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative unsigned multiply/divide execution unit. Shift-add
//               multiply and restoring divide, one iteration per clock,
//               WIDTH iterations per operation, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   rising-edge clock
//   reset_L  in   asynchronous active-low reset
//   start    in   operation request, sampled only while idle
//   abort    in   kills an in-flight operation (pipeline flush)
//   op       in   00 MUL low, 01 MULHU high, 10 DIVU quotient, 11 REMU rem
//   A        in   multiplicand / dividend
//   B        in   multiplier / divisor
//   rd_in    in   destination register index, captured with the operands
//   busy     out  high while calculating and during the done cycle
//   done     out  one-cycle result-valid pulse
//   result   out  write-back value, held until the next completed operation
//   rd_out   out  captured rd_in, aligned with result
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [4:0]         r_rd;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [WIDTH-1:0]   r_opnd;
  // The 2*WIDTH accumulator is split into two halves shared by both ops:
  //   multiply: {r_hi, r_lo} is the product register; r_lo starts as the
  //             multiplier and shifts right, product bits enter at its top.
  //   divide:   r_hi is the partial remainder; r_lo starts as the dividend
  //             and shifts left, quotient bits enter at its bottom.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  // One iteration of the selected algorithm.
  always_comb begin
    w_sum    = '0;
    w_shift  = '0;
    w_diff   = '0;
    w_borrow = 1'b0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (!r_op[1]) begin
      // Shift-add: add multiplicand into the high half when the current
      // multiplier LSB is set, then shift the whole product right by one.
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      // Restoring step: bring in the next dividend bit, trial-subtract.
      // While the remainder stays below the divisor the shifted value is
      // below 2*divisor, so the top bit of the WIDTH+1 bit difference is
      // exactly the borrow. With a zero divisor nothing ever borrows, which
      // naturally yields an all-ones quotient and remainder equal to A.
      w_shift  = {r_hi, r_lo[WIDTH-1]};
      w_diff   = w_shift - {1'b0, r_opnd};
      w_borrow = w_diff[WIDTH];
      w_hi_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_borrow};
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_rd    <= 5'd0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= 5'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_op    <= op;
            r_rd    <= rd_in;
            r_opnd  <= op[1] ? B : A;
            r_lo    <= op[1] ? A : B;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
            busy    <= 1'b1;
          end
        end

        CALC: begin
          // Abort wins even on the final iteration: a flushed operation
          // must never write back.
          if (abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == c_last) begin
              r_cnt   <= '0;
              // op[0] selects the upper half: MULHU high word, REMU remainder.
              result  <= r_op[0] ? w_hi_nxt : w_lo_nxt;
              rd_out  <= r_rd;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Stimulus pushes the
//               expected write-back (value, index, completion cycle) into a
//               queue; an independent monitor pops and compares on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic              clock;
  logic              reset_L;
  logic              start;
  logic              abort;
  logic [1:0]        op;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [4:0]        rd_in;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [4:0]        rd_out;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .start   (start),
    .abort   (abort),
    .op      (op),
    .A       (A),
    .B       (B),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [4:0]       rd;
    int               cyc;
  } exp_t;

  exp_t             r_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  logic [WIDTH-1:0] last_res = '0;
  logic [4:0]       last_rd  = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour, straight from the arithmetic definitions.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (o)
      2'b00:   return p[WIDTH-1:0];
      2'b01:   return p[2*WIDTH-1:WIDTH];
      2'b10:   return (b == 0) ? {WIDTH{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (r_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with result %h, expected none (cycle %0d)",
                 result, cyc);
      end else begin
        exp_t e;
        e = r_q.pop_front();
        chk("result", result, e.res);
        chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic junk_inputs();
    op    = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
    rd_in = 5'($urandom);
  endtask

  // Issue one operation from idle, scramble inputs after capture, wait for
  // completion and the return to idle.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] rd);
    exp_t e;
    @(negedge clock);
    start = 1'b1; op = o; A = a; B = b; rd_in = rd;
    @(negedge clock);
    start = 1'b0;
    e.res = model(o, a, b);
    e.rd  = rd;
    e.cyc = cyc + WIDTH;
    r_q.push_back(e);
    junk_inputs();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (WIDTH + 1) @(negedge clock);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    last_res = e.res;
    last_rd  = rd;
  endtask

  initial begin
    exp_t e;
    reset_L = 1'b0; start = 1'b0; abort = 1'b0;
    op = 2'b00; A = '0; B = '0; rd_in = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    reset_L = 1'b1;

    // Directed vectors
    run_op(2'b00, 32'd7, 32'd6, 5'd5);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(2'b10, 32'd100, 32'd7, 5'd3);
    run_op(2'b11, 32'd100, 32'd7, 5'd4);
    run_op(2'b10, 32'h8000_0000, 32'd1, 5'd6);
    run_op(2'b10, 32'd5, 32'd0, 5'd7);
    run_op(2'b11, 32'd5, 32'd0, 5'd8);

    // start together with abort in idle is ignored
    @(negedge clock);
    start = 1'b1; abort = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9; rd_in = 5'd9;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", {31'd0, busy}, 32'd0);

    // Abort at iteration 10, with an ignored start pulse mid-calculation
    @(negedge clock);
    start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd4; rd_in = 5'd12;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'b10; A = 32'd77; B = 32'd5; rd_in = 5'd20;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result_held", result, last_res);
    chk("abort_rd_held", {27'd0, rd_out}, {27'd0, last_rd});
    repeat (40) @(negedge clock);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-calculation
    @(negedge clock);
    start = 1'b1; op = 2'b00; A = 32'd11; B = 32'd13; rd_in = 5'd17;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (40) @(negedge clock);
    chk("after_rst_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high: DIVU 9/2 then MUL 2*2
    @(negedge clock);
    start = 1'b1; op = 2'b10; A = 32'd9; B = 32'd2; rd_in = 5'd3;
    @(negedge clock);
    e.res = 32'd4; e.rd = 5'd3; e.cyc = cyc + WIDTH;
    r_q.push_back(e);
    e.res = 32'd4; e.rd = 5'd4; e.cyc = cyc + 2 * WIDTH + 2;
    r_q.push_back(e);
    op = 2'b00; A = 32'd2; B = 32'd2; rd_in = 5'd4;
    repeat (WIDTH + 2) @(negedge clock);
    start = 1'b0;
    junk_inputs();
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    repeat (WIDTH + 1) @(negedge clock);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]       ro;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ro = 2'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 5'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    while (r_q.size() != 0) begin
      e = r_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_done: got no done, expected result %h rd %0d at cycle %0d",
               e.res, e.rd, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
